// File: rtl/diff_pkg.sv
// Shared constants and signed clamping helper for the difference unit.
package diff_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int LANES     = 3;

  // Clamp a signed value into the range of a width-bit signed word.
  function automatic logic signed [63:0] sat_w(
    input logic signed [63:0] value,
    input int                 width
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi)
      sat_w = hi;
    else if (value < lo)
      sat_w = lo;
    else
      sat_w = value;
  endfunction

endpackage

// File: rtl/diff_lane.sv
// One lane: saturated delta stage, then
// weight- and activation-scaled products.
module diff_lane
  import diff_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] w,
  output logic [DW-1:0] start_o,
  output logic [DW-1:0] to_all_o,
  output logic [DW-1:0] dense_o
);

  logic signed [DW-1:0]   d_q, d_d;
  logic signed [DW-1:0]   xr_q, xr_d;
  logic signed [DW-1:0]   wr_q, wr_d;
  logic        [DW-1:0]   to_all_q, to_all_d;
  logic        [DW-1:0]   dense_q, dense_d;

  logic signed [DW:0]     sub;
  logic signed [2*DW-1:0] p_to, p_de;
  logic signed [2*DW-1:0] s_to, s_de;

  always_comb begin
    sub  = (DW+1)'($signed(x)) - (DW+1)'($signed(w));
    d_d  = DW'(sat_w(64'(sub), DW));
    xr_d = $signed(x);
    wr_d = $signed(w);

    // Full-width products; the arithmetic shift floors toward -inf.
    p_to = (2*DW)'(wr_q) * (2*DW)'(d_q);
    p_de = (2*DW)'(xr_q) * (2*DW)'(d_q);
    s_to = p_to >>> FRAC_BITS;
    s_de = p_de >>> FRAC_BITS;

    to_all_d = DW'(sat_w(64'(s_to), DW));
    dense_d  = DW'(sat_w(64'(s_de), DW));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q      <= '0;
      xr_q     <= '0;
      wr_q     <= '0;
      to_all_q <= '0;
      dense_q  <= '0;
    end else begin
      d_q      <= d_d;
      xr_q     <= xr_d;
      wr_q     <= wr_d;
      to_all_q <= to_all_d;
      dense_q  <= dense_d;
    end
  end

  assign start_o  = d_q;
  assign to_all_o = to_all_q;
  assign dense_o  = dense_q;

endmodule

// File: rtl/different.sv
// Per-lane gradient unit: packs/unpacks lanes
// around independent diff_lane pipelines.
module different
  import diff_pkg::*;
#(
  parameter int data_size = DATA_W,
  parameter int size      = LANES
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [size*data_size-1:0] x,
  input  logic [size*data_size-1:0] weight,
  output logic [size*data_size-1:0] diff_start_out,
  output logic [size*data_size-1:0] diff_to_all_out,
  output logic [size*data_size-1:0] diff_dense_out
);

  for (genvar k = 0; k < size; k++) begin : g_lane
    diff_lane #(
      .DW(data_size)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .x       (x[(k+1)*data_size-1 -: data_size]),
      .w       (weight[(k+1)*data_size-1 -: data_size]),
      .start_o (diff_start_out[(k+1)*data_size-1 -: data_size]),
      .to_all_o(diff_to_all_out[(k+1)*data_size-1 -: data_size]),
      .dense_o (diff_dense_out[(k+1)*data_size-1 -: data_size])
    );
  end

endmodule

// File: tb/tb_different.sv
// Bench for different: vector table, random
// stream and reset sequences via a scoreboard.
module tb_different;

  localparam int DW = 16;
  localparam int N  = 3;
  localparam int W  = DW * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] x, weight;
  logic [W-1:0] so, to, de;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [W-1:0] t;
    logic [W-1:0] d;
  } prod_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] w;
    logic [W-1:0] es;
    logic [W-1:0] et;
    logic [W-1:0] ed;
  } vec_t;

  logic [W-1:0] q_s[$];
  prod_t        q_p[$];
  vec_t         tbl[7];

  always #5 clk = ~clk;

  different #(
    .data_size(DW),
    .size     (N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .x              (x),
    .weight         (weight),
    .diff_start_out (so),
    .diff_to_all_out(to),
    .diff_dense_out (de)
  );

  task automatic chk(input string n,
                     input logic [W-1:0] a,
                     input logic [W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               n, a, e, $time);
    end
  endtask

  function automatic logic [DW-1:0] msat(
    input longint v);
    if (v > 32767)
      return 16'h7fff;
    if (v < -32768)
      return 16'h8000;
    return v[DW-1:0];
  endfunction

  task automatic model(input  logic [W-1:0] xv,
                       input  logic [W-1:0] wv,
                       output logic [W-1:0] es,
                       output logic [W-1:0] et,
                       output logic [W-1:0] ed);
    longint xi, wi, di;
    logic [DW-1:0] dk;
    es = '0;
    et = '0;
    ed = '0;
    for (int k = 0; k < N; k++) begin
      xi = longint'($signed(xv[k*DW +: DW]));
      wi = longint'($signed(wv[k*DW +: DW]));
      dk = msat(xi - wi);
      di = longint'($signed(dk));
      es[k*DW +: DW] = dk;
      et[k*DW +: DW] = msat((wi * di) >>> 8);
      ed[k*DW +: DW] = msat((xi * di) >>> 8);
    end
  endtask

  task automatic step(input logic [W-1:0] xv,
                      input logic [W-1:0] wv,
                      input logic [W-1:0] es,
                      input logic [W-1:0] et,
                      input logic [W-1:0] ed);
    prod_t p;
    x      = xv;
    weight = wv;
    q_s.push_back(es);
    q_p.push_back('{et, ed});
    @(negedge clk);
    chk("start", so, q_s.pop_front());
    if (q_p.size() > 1) begin
      p = q_p.pop_front();
      chk("to_all", to, p.t);
      chk("dense", de, p.d);
    end
  endtask

  task automatic run(input logic [W-1:0] xv,
                     input logic [W-1:0] wv);
    logic [W-1:0] es, et, ed;
    model(xv, wv, es, et, ed);
    step(xv, wv, es, et, ed);
  endtask

  // After reset the stage-2 outputs first show the zeroed stage-1 product.
  task automatic restart();
    q_s.delete();
    q_p.delete();
    q_p.push_back('{W'(0), W'(0)});
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(1) == 1)
        r[k*DW +: DW] = 16'($urandom);
      else
        r[k*DW +: DW] =
          16'($urandom_range(0, 2048)) - 16'h0400;
    end
    return r;
  endfunction

  task automatic chk_zero(input string n);
    chk({n, "_start"}, so, '0);
    chk({n, "_to_all"}, to, '0);
    chk({n, "_dense"}, de, '0);
  endtask

  initial begin
    tbl[0] = '{{3{16'h0300}}, {3{16'h0100}},
               {3{16'h0200}}, {3{16'h0200}},
               {3{16'h0600}}};
    tbl[1] = '{{3{16'h0080}}, {3{16'h0180}},
               {3{16'hff00}}, {3{16'hfe80}},
               {3{16'hff80}}};
    tbl[2] = '{{3{16'h7f00}}, {3{16'h8100}},
               {3{16'h7fff}}, {3{16'h8000}},
               {3{16'h7fff}}};
    tbl[3] = '{{16'h0100, 16'h0200, 16'h0300},
               W'(0),
               {16'h0100, 16'h0200, 16'h0300},
               W'(0),
               {16'h0100, 16'h0400, 16'h0900}};
    tbl[4] = '{{3{16'h1234}}, {3{16'h1234}},
               W'(0), W'(0), W'(0)};
    tbl[5] = '{{3{16'h8000}}, W'(0),
               {3{16'h8000}}, W'(0),
               {3{16'h7fff}}};
    tbl[6] = '{{16'h8000, 16'h0300, 16'h0080},
               {16'h8000, 16'h0100, 16'h0180},
               {16'h0000, 16'h0200, 16'hff00},
               {16'h0000, 16'h0200, 16'hfe80},
               {16'h0000, 16'h0600, 16'hff80}};

    rst_n  = 1'b0;
    x      = '0;
    weight = '0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      x      = rnd();
      weight = rnd();
      @(negedge clk);
      chk_zero("rst_hold");
    end

    rst_n = 1'b1;
    restart();

    for (int i = 0; i < 7; i++)
      step(tbl[i].x, tbl[i].w,
           tbl[i].es, tbl[i].et, tbl[i].ed);

    for (int i = 0; i < 10; i++)
      run(rnd(), rnd());

    x      = rnd();
    weight = rnd();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    @(negedge clk);
    chk_zero("rst_mid");
    rst_n = 1'b1;
    restart();

    for (int i = 0; i < 6; i++)
      run(rnd(), rnd());
    run('0, '0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
